mem_stage: RTL and testbench

- Memory-access stage, directly downstream of the execute stage; consumes the ALU result and rs2 value each instruction.
- Non-memory instructions pass through as a registered MEM/WB pipeline register.
- Loads and stores drive a req/gnt + rvalid data-memory interface. Store data is byte-lane aligned; load data is aligned and extended.
- Upstream is stalled while an access is outstanding.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_align.sv | 41 ++++
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage:
// RV32I load/store funct3 encodings and the access FSM states.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  // Low two funct3 bits give log2 of the access size in bytes.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (f3[1:0] == 2'b01): m = off[0];
      (f3[1:0] == 2'b10): m = (off != 2'b00);
      default:            m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (off_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  assign half_sel = off_i[1] ? rdata_i[31:16]
                             : rdata_i[15:0];

  always_comb begin
    data_o = '0;
    unique case (funct3_i)
      F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:  data_o = rdata_i;
      F3_LBU: data_o = {24'd0, byte_sel};
      F3_LHU: data_o = {16'd0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: MEM/WB pipeline register plus a
// req/gnt + rvalid data-memory master for loads and stores.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      rs2_val_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [2:0]           funct3_i,
  input  logic [REGADDR_W-1:0] rd_i,
  input  logic                 reg_write_i,
  output logic                 dmem_req_o,
  input  logic                 dmem_gnt_i,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_rvalid_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 wb_valid_o,
  output logic [XLEN-1:0]      wb_result_o,
  output logic [REGADDR_W-1:0] wb_rd_o,
  output logic                 wb_reg_write_o,
  output logic                 fault_o
);

  state_e state_q, state_d;

  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [2:0]           f3_q, f3_d;
  logic [REGADDR_W-1:0] rd_q, rd_d;
  logic                 rw_q, rw_d;
  logic                 st_q, st_d;

  logic                 wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]      wb_result_q, wb_result_d;
  logic [REGADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                 wb_rw_q, wb_rw_d;
  logic                 fault_q, fault_d;

  logic            accept;
  logic            is_mem;
  logic            is_st;
  logic            illegal;
  logic            acc_fault;
  logic            rd_nz;
  logic [1:0]      off;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] ld_data;
  logic            in_req;

  assign ex_ready_o = (state_q == IDLE) && !rst;
  assign accept     = ex_valid_i && ex_ready_o;
  assign is_mem     = mem_read_i || mem_write_i;
  assign is_st      = mem_write_i;
  assign off        = alu_result_i[1:0];
  assign rd_nz      = (rd_i != '0);

  // Loads reject 011/11x; stores reject anything at or above 011.
  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      is_st:   illegal = funct3_i[2]
                      || (funct3_i[1:0] == 2'b11);
      default: illegal = (funct3_i == 3'b011)
                      || (funct3_i[2:1] == 2'b11);
    endcase
  end

  assign acc_fault = illegal || misaligned(funct3_i, off);

  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = rs2_val_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << off;
        lane_wdata = {4{rs2_val_i[7:0]}};
      end
      2'b01: begin
        lane_be    = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{rs2_val_i[15:0]}};
      end
      2'b10: begin
        lane_be    = 4'b1111;
        lane_wdata = rs2_val_i;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = rs2_val_i;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    st_d        = st_q;
    wb_valid_d  = 1'b0;
    fault_d     = 1'b0;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !is_mem) begin
          wb_valid_d  = 1'b1;
          wb_result_d = alu_result_i;
          wb_rd_d     = rd_i;
          wb_rw_d     = reg_write_i && rd_nz;
        end else if (accept && acc_fault) begin
          wb_valid_d  = 1'b1;
          fault_d     = 1'b1;
          wb_result_d = alu_result_i;
          wb_rd_d     = rd_i;
          wb_rw_d     = 1'b0;
        end else if (accept) begin
          addr_d  = alu_result_i;
          wdata_d = lane_wdata;
          be_d    = lane_be;
          f3_d    = funct3_i;
          rd_d    = rd_i;
          rw_d    = reg_write_i && rd_nz && !is_st;
          st_d    = is_st;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt_i && st_q) begin
          wb_valid_d  = 1'b1;
          wb_result_d = addr_q;
          wb_rd_d     = rd_q;
          wb_rw_d     = 1'b0;
          state_d     = IDLE;
        end else if (dmem_gnt_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          wb_valid_d  = 1'b1;
          wb_result_d = ld_data;
          wb_rd_d     = rd_q;
          wb_rw_d     = rw_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      st_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      st_q        <= st_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      fault_q     <= fault_d;
    end
  end

  // Bus outputs are forced to zero outside REQ so idle bus is quiet.
  assign in_req       = (state_q == REQ);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && st_q;
  assign dmem_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o    = in_req ? be_q : 4'b0000;
  assign dmem_wdata_o = in_req ? wdata_q : '0;

  assign wb_valid_o     = wb_valid_q;
  assign wb_result_o    = wb_result_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_reg_write_o = wb_rw_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random ops against
// a byte-level reference model, and multi-cycle corner sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] alu_result_i;
  logic [31:0] rs2_val_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        reg_write_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic        fault_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .alu_result_i   (alu_result_i),
    .rs2_val_i      (rs2_val_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .funct3_i       (funct3_i),
    .rd_i           (rd_i),
    .reg_write_i    (reg_write_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .wb_valid_o     (wb_valid_o),
    .wb_result_o    (wb_result_o),
    .wb_rd_o        (wb_rd_o),
    .wb_reg_write_o (wb_reg_write_o),
    .fault_o        (fault_o)
  );

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    int          gd;
    int          rdl;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
    logic        chk_res;
    logic        e_fault;
    logic        e_rw;
    int          e_stall;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t tv(
    input logic mr, input logic mw, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] rs2,
    input logic [31:0] rdata, input logic [4:0] rd,
    input logic rw, input int gd, input int rdl,
    input logic e_req, input logic e_we,
    input logic [31:0] e_addr, input logic [3:0] e_be,
    input logic [31:0] e_wdata, input logic [31:0] e_res,
    input logic chk_res, input logic e_fault,
    input logic e_rw, input int e_stall);
    vec_t v;
    v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr;
    v.rs2 = rs2; v.rdata = rdata; v.rd = rd; v.rw = rw;
    v.gd = gd; v.rdl = rdl; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_res = e_res; v.chk_res = chk_res;
    v.e_fault = e_fault; v.e_rw = e_rw; v.e_stall = e_stall;
    return v;
  endfunction

  // Byte-level view: an access covers sz bytes starting at the
  // byte offset; anything else about lanes follows from that.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int sz, off;
    logic ill, mis, mem;
    logic [31:0] mask, val;
    v = vi;
    v.e_req = 0; v.e_we = 0; v.e_addr = 0; v.e_be = 0;
    v.e_wdata = 0; v.e_res = 0; v.chk_res = 0;
    v.e_fault = 0; v.e_rw = 0; v.e_stall = 0;
    mem = v.mr | v.mw;
    sz  = (v.f3[1:0] == 2'd3) ? 8 : (1 << v.f3[1:0]);
    off = int'(v.addr[1:0]);
    if (v.mw) ill = (v.f3 >= 3'd3);
    else ill = (v.f3 == 3'd3) || (v.f3 == 3'd6) || (v.f3 == 3'd7);
    mis = (off % sz) != 0;
    if (!mem) begin
      v.chk_res = 1; v.e_res = v.addr;
      v.e_rw = v.rw && (v.rd != 0);
    end else if (ill || mis) begin
      v.e_fault = 1;
    end else begin
      v.e_req = 1; v.e_we = v.mw;
      v.e_addr = v.addr & ~32'h3;
      if (v.mw) begin
        v.e_be = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++)
          v.e_wdata[8*i +: 8] = v.rs2[8*(i % sz) +: 8];
        v.e_stall = v.gd + 1;
      end else begin
        mask = (sz == 4) ? 32'hFFFF_FFFF
                         : ((32'h1 << (8*sz)) - 32'h1);
        val = (v.rdata >> (8*off)) & mask;
        if (!v.f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
        v.e_res = val; v.chk_res = 1;
        v.e_rw = v.rw && (v.rd != 0);
        v.e_stall = v.gd + 1 + v.rdl;
      end
    end
    return v;
  endfunction

  // Called at a negedge; returns at the negedge showing wb_valid_o.
  task automatic run_vec(input vec_t v, input logic noise,
                         input string tag);
    logic done = 0, req_seen = 0, granted = 0, unstable = 0;
    int nreq = 0, post = 0, stall = 0;
    logic [31:0] r_addr = 0, r_wdata = 0;
    logic [3:0] r_be = 0;
    logic r_we = 0;
    chk({tag, " ready_before"}, 32'(ex_ready_o), 32'd1);
    ex_valid_i   = 1;
    mem_read_i   = v.mr;
    mem_write_i  = v.mw;
    funct3_i     = v.f3;
    alu_result_i = v.addr;
    rs2_val_i    = v.rs2;
    rd_i         = v.rd;
    reg_write_i  = v.rw;
    dmem_rvalid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    dmem_rdata_i  = $urandom;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      ex_valid_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
      dmem_rdata_i = $urandom;
      if (wb_valid_o) begin
        done = 1;
        break;
      end
      if (!ex_ready_o) stall++;
      if (dmem_req_o) begin
        if (!req_seen) begin
          r_addr = dmem_addr_o; r_be = dmem_be_o;
          r_wdata = dmem_wdata_o; r_we = dmem_we_o;
        end else if (r_addr !== dmem_addr_o || r_be !== dmem_be_o
                  || r_wdata !== dmem_wdata_o
                  || r_we !== dmem_we_o) begin
          unstable = 1;
        end
        req_seen = 1;
        nreq++;
        if (noise) dmem_rvalid_i = 1'($urandom_range(0, 1));
        if (nreq > v.gd) begin
          dmem_gnt_i = 1;
          granted = 1;
        end
      end else if (granted) begin
        post++;
        if (post == v.rdl) begin
          dmem_rvalid_i = 1;
          dmem_rdata_i  = v.rdata;
        end
      end
    end
    chk({tag, " wb_timeout"}, 32'(done), 32'd1);
    chk({tag, " req_seen"}, 32'(req_seen), 32'(v.e_req));
    if (v.e_req) begin
      chk({tag, " dmem_addr"}, r_addr, v.e_addr);
      chk({tag, " dmem_we"}, 32'(r_we), 32'(v.e_we));
      chk({tag, " req_stable"}, 32'(unstable), 32'd0);
      if (v.e_we) begin
        chk({tag, " dmem_be"}, 32'(r_be), 32'(v.e_be));
        chk({tag, " dmem_wdata"}, r_wdata, v.e_wdata);
      end
    end
    chk({tag, " fault"}, 32'(fault_o), 32'(v.e_fault));
    chk({tag, " reg_write"}, 32'(wb_reg_write_o), 32'(v.e_rw));
    chk({tag, " stall"}, 32'(stall), 32'(v.e_stall));
    if (v.chk_res) begin
      chk({tag, " result"}, wb_result_o, v.e_res);
      chk({tag, " rd"}, 32'(wb_rd_o), 32'(v.rd));
    end
  endtask

  vec_t tab[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; ex_valid_i = 0; alu_result_i = 0; rs2_val_i = 0;
    mem_read_i = 0; mem_write_i = 0; funct3_i = 0; rd_i = 0;
    reg_write_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
    dmem_rdata_i = 0;

    // m m f3  addr     rs2       rdata     rd rw gd rdl
    // req we  e_addr   be  wdata   result  chk flt rw stall
    tab.push_back(tv(0,0,3'b000,32'h1234,0,0,5,1,0,0,
      0,0,0,4'h0,0,32'h1234,1,0,1,0));
    tab.push_back(tv(0,1,3'b000,32'h103,32'hAABBCCDD,0,6,1,2,0,
      1,1,32'h100,4'b1000,32'hDDDDDDDD,0,0,0,0,3));
    tab.push_back(tv(1,0,3'b000,32'h202,0,32'h0080_0000,9,1,0,3,
      1,0,32'h200,4'h0,0,32'hFFFF_FF80,1,0,1,4));
    tab.push_back(tv(1,0,3'b100,32'h202,0,32'h0080_0000,9,1,0,3,
      1,0,32'h200,4'h0,0,32'h0000_0080,1,0,1,4));
    tab.push_back(tv(1,0,3'b001,32'h301,0,0,4,1,0,1,
      0,0,0,4'h0,0,0,0,1,0,0));
    tab.push_back(tv(0,1,3'b001,32'h2,32'h12345678,0,1,0,0,0,
      1,1,32'h0,4'b1100,32'h56785678,0,0,0,0,1));
    tab.push_back(tv(0,1,3'b010,32'h40,32'hCAFEF00D,0,1,0,1,0,
      1,1,32'h40,4'b1111,32'hCAFEF00D,0,0,0,0,2));
    tab.push_back(tv(1,0,3'b101,32'h6,0,32'h8001_7FFF,11,1,0,1,
      1,0,32'h4,4'h0,0,32'h0000_8001,1,0,1,2));
    tab.push_back(tv(1,0,3'b001,32'h6,0,32'h8001_7FFF,12,1,0,1,
      1,0,32'h4,4'h0,0,32'hFFFF_8001,1,0,1,2));
    tab.push_back(tv(1,0,3'b010,32'h10,0,32'hDEADBEEF,13,1,1,1,
      1,0,32'h10,4'h0,0,32'hDEADBEEF,1,0,1,3));
    tab.push_back(tv(1,0,3'b010,32'h12,0,0,14,1,0,1,
      0,0,0,4'h0,0,0,0,1,0,0));
    tab.push_back(tv(1,0,3'b011,32'h0,0,0,15,1,0,1,
      0,0,0,4'h0,0,0,0,1,0,0));
    tab.push_back(tv(0,1,3'b011,32'h0,0,0,15,1,0,1,
      0,0,0,4'h0,0,0,0,1,0,0));
    tab.push_back(tv(1,0,3'b010,32'h20,0,32'h12345678,0,1,0,1,
      1,0,32'h20,4'h0,0,32'h12345678,1,0,0,2));
    tab.push_back(tv(1,1,3'b010,32'h24,32'h11,0,3,1,0,0,
      1,1,32'h24,4'b1111,32'h11,0,0,0,0,1));
    tab.push_back(tv(0,0,3'b010,32'h77,0,0,0,1,0,0,
      0,0,0,4'h0,0,32'h77,1,0,0,0));

    @(negedge clk);
    @(negedge clk);
    chk("rst ex_ready", 32'(ex_ready_o), 32'd0);
    chk("rst dmem_req", 32'(dmem_req_o), 32'd0);
    chk("rst dmem_we", 32'(dmem_we_o), 32'd0);
    chk("rst dmem_addr", dmem_addr_o, 32'd0);
    chk("rst dmem_be", 32'(dmem_be_o), 32'd0);
    chk("rst dmem_wdata", dmem_wdata_o, 32'd0);
    chk("rst wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst wb_result", wb_result_o, 32'd0);
    chk("rst wb_rd", 32'(wb_rd_o), 32'd0);
    chk("rst wb_rw", 32'(wb_reg_write_o), 32'd0);
    chk("rst fault", 32'(fault_o), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("post_rst ex_ready", 32'(ex_ready_o), 32'd1);

    foreach (tab[i]) run_vec(tab[i], 1'b0, $sformatf("vec%0d", i));

    for (int n = 0; n < 200; n++) begin
      vec_t v;
      int kind;
      kind = $urandom_range(0, 3);
      v.mr = (kind == 1) || (kind == 3);
      v.mw = (kind == 2) || (kind == 3);
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.rs2 = $urandom;
      v.rdata = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.rw = 1'($urandom_range(0, 1));
      v.gd = $urandom_range(0, 3);
      v.rdl = $urandom_range(1, 3);
      run_vec(model(v), 1'b1, $sformatf("rnd%0d", n));
    end

    // Reset while waiting for read data; the late rvalid is dropped.
    begin
      int pulses = 0;
      int not_ready = 0;
      ex_valid_i = 1; mem_read_i = 1; mem_write_i = 0;
      funct3_i = 3'b010; alu_result_i = 32'h10; rd_i = 3;
      reg_write_i = 1;
      @(negedge clk);
      ex_valid_i = 0;
      chk("rstwait req", 32'(dmem_req_o), 32'd1);
      dmem_gnt_i = 1;
      @(negedge clk);
      dmem_gnt_i = 0;
      chk("rstwait in_wait", 32'(ex_ready_o), 32'd0);
      rst = 1;
      @(negedge clk);
      rst = 0;
      dmem_rvalid_i = 1; dmem_rdata_i = 32'h5555AAAA;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        dmem_rvalid_i = 0;
        if (wb_valid_o) pulses++;
        if (!ex_ready_o) not_ready++;
      end
      chk("rstwait wb_pulses", 32'(pulses), 32'd0);
      chk("rstwait not_ready", 32'(not_ready), 32'd0);
      chk("rstwait req_idle", 32'(dmem_req_o), 32'd0);
    end

    // LW followed by ADD: ADD waits, results stay in program order.
    begin
      logic [36:0] wq[$];
      int acc_before = -1;
      int phase = 0;
      logic add_on = 0;
      ex_valid_i = 1; mem_read_i = 1; mem_write_i = 0;
      funct3_i = 3'b010; alu_result_i = 32'h10; rd_i = 7;
      reg_write_i = 1;
      for (int k = 0; k < 40 && wq.size() < 2; k++) begin
        @(negedge clk);
        dmem_gnt_i = 0; dmem_rvalid_i = 0;
        if (wb_valid_o) wq.push_back({wb_rd_o, wb_result_o});
        if (k == 0) begin
          mem_read_i = 0; alu_result_i = 32'h55; rd_i = 8;
          add_on = 1;
        end else if (add_on && ex_ready_o) begin
          acc_before = wq.size();
          add_on = 0;
        end else if (!add_on && acc_before >= 0) begin
          ex_valid_i = 0;
        end
        if (dmem_req_o) begin
          dmem_gnt_i = 1; phase = 1;
        end else if (phase == 1) begin
          dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF;
          phase = 2;
        end
      end
      ex_valid_i = 0;
      chk("b2b pulses", 32'(wq.size()), 32'd2);
      chk("b2b add_after_lw", 32'(acc_before), 32'd1);
      if (wq.size() == 2) begin
        chk("b2b first", wq[0][31:0], 32'hDEADBEEF);
        chk("b2b first_rd", 32'(wq[0][36:32]), 32'd7);
        chk("b2b second", wq[1][31:0], 32'h55);
        chk("b2b second_rd", 32'(wq[1][36:32]), 32'd8);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
